sram_write: RTL
===============

# sram_write

Write-cycle controller for the external asynchronous 32-bit SRAM. It accepts one word-write request over a valid/ready handshake and sequences the SRAM control pins through setup, write-pulse and hold phases. It signals completion with a one-cycle `wfin` pulse. It sits between the memory-stage store path and the SRAM pins, alongside the read-cycle controller that shares the same bus.

## Interface
Parameters:
- `ADDR_W`, 20: SRAM word-address width.
- `SETUP_CYCLES`, 1: cycles the address, data and `ce_n` are valid before `we_n` falls; ≥1.
- `WE_CYCLES`, 2: `we_n` low-pulse width in cycles; ≥1.
- `HOLD_CYCLES`, 1: cycles the address and data are held after `we_n` rises; ≥1.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: a write request is present.
- `req_ready` out 1: the request is accepted on a clock edge where `req_valid` and `req_ready` are both high.
- `req_addr` in ADDR_W: word address.
- `req_data` in 32: write data.
- `req_be` in 4: byte enables, active-high, bit i covers data[8i+7:8i].
- `sram_addr` out ADDR_W: address pins.
- `sram_dq_o` out 32: data driven onto the bus.
- `sram_dq_oe` out 1: tristate enable for `sram_dq_o`, high = drive.
- `sram_be_n` out 4: byte-lane selects, active-low.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n` out 1 each: chip/output/write enables, active-low.
- `busy` out 1: high in any state other than IDLE.
- `wfin` out 1: one-cycle pulse when a write completes.

## Operation
- States: IDLE → SETUP → WRITE → HOLD → IDLE.
- A phase counter counts down each phase's cycle count. The state transitions when the counter reaches 0.
- IDLE:
  - `req_ready`=1.
  - On accept, latch addr/data/be and go to SETUP.
- SETUP:
  - `sram_addr`, `sram_dq_o` and `sram_be_n`=~be are driven from the latched values.
  - `sram_ce_n`=0, `sram_dq_oe`=1, `sram_we_n`=1.
- WRITE: same as SETUP, except `sram_we_n`=0.
  - If the latched be==4'b0000, `sram_we_n` stays 1; the phase is still timed and `wfin` is still pulsed.
- HOLD: `sram_we_n`=1, `sram_ce_n`=0. Addr, data and `dq_oe` are held.
- Leaving HOLD: `wfin`=1 for exactly one cycle. The next state is IDLE, or SETUP if a buffered request exists (see Configuration).
- `sram_oe_n` is constantly 1, which prevents bus contention.
- Latched values are never changed mid-cycle. Input changes after acceptance are ignored.
- Reset values: `sram_ce_n`=`sram_oe_n`=`sram_we_n`=1, `sram_be_n`=4'hF, `sram_dq_oe`=0, `sram_addr`=0, `sram_dq_o`=0, `busy`=0, `wfin`=0, `req_ready`=0 during reset. The state is IDLE.
- Reset mid-operation: at the next edge all pins return to their reset values with no `wfin`. Any buffered request is discarded.

## Timing
- Accept on edge E0. SETUP occupies cycles 1..S, WRITE S+1..S+W, HOLD S+W+1..S+W+H, and `wfin` is high in cycle S+W+H+1.
- With the defaults: SETUP in cycle 1, `we_n` low in cycles 2–3, HOLD in cycle 4, `wfin` in cycle 5.
- All outputs are registered; no combinational path exists from `req_*` to the SRAM pins.
- Throughput without the buffer is one write per S+W+H+1 cycles, since `req_ready` is high only in IDLE.
- `req_valid` held high in the `wfin` cycle is accepted in that cycle, with `wfin` and `req_ready` both high.

## Configuration
- `SRAM_WRITE_BUF_EN` defined: a one-entry request buffer is compiled in.
  - `req_ready` = buffer empty, in any state.
  - A request accepted while busy is stored.
  - On leaving HOLD with the buffer full, the FSM goes directly to SETUP in the `wfin` cycle and the buffer empties. This gives back-to-back writes at one per S+W+H cycles.
- `SRAM_WRITE_BUF_EN` undefined: no buffer. `req_ready` = (state==IDLE).

## Structure
- Package `sram_pkg` holds:
  - the state enum type `sram_wr_state_t`;
  - the default timing constants (`SRAM_SETUP_CYC`, `SRAM_WE_CYC`, `SRAM_HOLD_CYC`);
  - the pin idle-value constants, which the read controller also uses.
- Sub-module `sram_phase_cnt`: a loadable down-counter with a `zero` flag, instantiated once.

## Test plan
- Reset: assert `rst` for 2 cycles → all SRAM pins at their idle values, `busy`=0, `wfin`=0.
- Single write: addr=0x00010, data=0xDEADBEEF, be=4'hF → `we_n` low in cycles 2–3, `be_n`=0, `dq_o`=0xDEADBEEF held through cycle 4, `wfin` in cycle 5.
- Partial write: be=4'b0101 → `sram_be_n`=4'b1010 throughout. be=0 → `we_n` never low, `wfin` still in cycle 5.
- Reset mid-write: assert `rst` in cycle 2 → `we_n`=1, `ce_n`=1 and `dq_oe`=0 at the next edge, and no `wfin`.
- Back-to-back requests: two requests with valid held high. Without the buffer, the second is accepted in the `wfin` cycle. With `SRAM_WRITE_BUF_EN`, the second is accepted in cycle 1 and its SETUP begins in cycle 5.
- Non-default parameters: SETUP=2, WE=3, HOLD=2 → `we_n` low in cycles 3–5, `wfin` in cycle 8.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the external asynchronous SRAM controllers:
// the write FSM state type, default phase timings and the pin idle values.
// The idle values are also used by the read-cycle controller on the same bus.
package sram_pkg;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_SETUP = 2'd1,
        WR_WRITE = 2'd2,
        WR_HOLD  = 2'd3
    } sram_wr_state_t;

    // Default write-cycle phase lengths, in clock cycles
    localparam int SRAM_SETUP_CYC = 1;
    localparam int SRAM_WE_CYC    = 2;
    localparam int SRAM_HOLD_CYC  = 1;

    // Pin values whenever no controller owns the bus
    localparam logic       SRAM_CE_N_IDLE  = 1'b1;
    localparam logic       SRAM_OE_N_IDLE  = 1'b1;
    localparam logic       SRAM_WE_N_IDLE  = 1'b1;
    localparam logic       SRAM_DQ_OE_IDLE = 1'b0;
    localparam logic [3:0] SRAM_BE_N_IDLE  = 4'hF;

    // Largest of three phase lengths, used to size the phase counter
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sram_phase_cnt.sv
// Loadable down-counter timing one SRAM write phase. It saturates at zero,
// and the zero flag marks the last cycle of the current phase.
module sram_phase_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load a new phase length, otherwise count down and stop at zero
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sram_write.sv
// Write-cycle controller for the external asynchronous 32-bit SRAM.
// Sequences IDLE -> SETUP -> WRITE -> HOLD and pulses wfin on leaving HOLD.
// Optional feature: define SRAM_WRITE_BUF_EN to compile in a one-entry
// request buffer, which gives back-to-back writes without an idle cycle.
module sram_write
    import sram_pkg::*;
#(
    parameter int ADDR_W       = 20,
    parameter int SETUP_CYCLES = SRAM_SETUP_CYC,
    parameter int WE_CYCLES    = SRAM_WE_CYC,
    parameter int HOLD_CYCLES  = SRAM_HOLD_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [3:0]        req_be,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_dq_o,
    output logic              sram_dq_oe,
    output logic [3:0]        sram_be_n,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              busy,
    output logic              wfin
);

    localparam int MAX_CYC = max3(SETUP_CYCLES, WE_CYCLES, HOLD_CYCLES);
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    sram_wr_state_t    state;
    logic              zero;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_val;

    logic              fire;
    logic              hold_done;
    logic              take_req;
    logic              take_buf;
    logic              start;
    logic              idle_nx;
    logic              ready_nx;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic [3:0]        st_be;

    assign fire      = req_valid & req_ready;
    assign hold_done = (state == WR_HOLD) & zero;
    assign start     = take_req | take_buf;
    // Next cycle is IDLE when no new write starts from IDLE or the end of HOLD
    assign idle_nx   = ((state == WR_IDLE) | hold_done) & ~start;

    // The output-enable pin is never asserted by the write path
    assign sram_oe_n = SRAM_OE_N_IDLE;

`ifdef SRAM_WRITE_BUF_EN
    logic              buf_full;
    logic              buf_full_nx;
    logic              buf_store;
    logic [ADDR_W-1:0] buf_addr;
    logic [31:0]       buf_data;
    logic [3:0]        buf_be;

    // A request arriving when the FSM can start a write goes straight in;
    // anything else accepted while busy parks in the buffer.
    assign take_buf    = hold_done & buf_full;
    assign take_req    = fire & ((state == WR_IDLE) | (hold_done & ~buf_full));
    assign buf_store   = fire & ~take_req;
    assign buf_full_nx = take_buf ? 1'b0 : (buf_full | buf_store);
    assign ready_nx    = ~buf_full_nx;
    assign st_addr     = take_buf ? buf_addr : req_addr;
    assign st_data     = take_buf ? buf_data : req_data;
    assign st_be       = take_buf ? buf_be   : req_be;

    // One-entry request buffer; contents only matter while buf_full is set
    always_ff @(posedge clk) begin
        if (rst)
            buf_full <= 1'b0;
        else
            buf_full <= buf_full_nx;
        if (buf_store) begin
            buf_addr <= req_addr;
            buf_data <= req_data;
            buf_be   <= req_be;
        end
    end
`else
    assign take_buf = 1'b0;
    assign take_req = fire & (state == WR_IDLE);
    assign ready_nx = idle_nx;
    assign st_addr  = req_addr;
    assign st_data  = req_data;
    assign st_be    = req_be;
`endif

    // Reload the phase counter with (length - 1) on entry to each phase
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state)
            WR_IDLE:  if (start) begin
                          cnt_load = 1'b1;
                          cnt_val  = CNT_W'(SETUP_CYCLES - 1);
                      end
            WR_SETUP: if (zero) begin
                          cnt_load = 1'b1;
                          cnt_val  = CNT_W'(WE_CYCLES - 1);
                      end
            WR_WRITE: if (zero) begin
                          cnt_load = 1'b1;
                          cnt_val  = CNT_W'(HOLD_CYCLES - 1);
                      end
            WR_HOLD:  if (zero && start) begin
                          cnt_load = 1'b1;
                          cnt_val  = CNT_W'(SETUP_CYCLES - 1);
                      end
            default: ;
        endcase
    end

    sram_phase_cnt #(.W(CNT_W)) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (zero)
    );

    // Write FSM; every pin is registered and set on entry to its phase
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WR_IDLE;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= SRAM_DQ_OE_IDLE;
            sram_be_n  <= SRAM_BE_N_IDLE;
            sram_ce_n  <= SRAM_CE_N_IDLE;
            sram_we_n  <= SRAM_WE_N_IDLE;
            busy       <= 1'b0;
            wfin       <= 1'b0;
            req_ready  <= 1'b0;
        end else begin
            wfin      <= 1'b0;
            busy      <= ~idle_nx;
            req_ready <= ready_nx;
            case (state)
                WR_SETUP: if (zero) begin
                    state     <= WR_WRITE;
                    // All byte lanes disabled: time the pulse but keep we_n high
                    sram_we_n <= &sram_be_n;
                end
                WR_WRITE: if (zero) begin
                    state     <= WR_HOLD;
                    sram_we_n <= 1'b1;
                end
                WR_HOLD: if (zero) begin
                    state      <= WR_IDLE;
                    wfin       <= 1'b1;
                    sram_ce_n  <= SRAM_CE_N_IDLE;
                    sram_dq_oe <= SRAM_DQ_OE_IDLE;
                    sram_be_n  <= SRAM_BE_N_IDLE;
                    sram_we_n  <= SRAM_WE_N_IDLE;
                end
                default: ;
            endcase
            // A starting write (from IDLE or straight out of HOLD) overrides
            // the idle values above; the request is latched into the pin regs.
            if (start) begin
                state      <= WR_SETUP;
                sram_addr  <= st_addr;
                sram_dq_o  <= st_data;
                sram_be_n  <= ~st_be;
                sram_ce_n  <= 1'b0;
                sram_dq_oe <= 1'b1;
                sram_we_n  <= 1'b1;
            end
        end
    end

endmodule
